// File: rtl/runctrl_pkg.sv
// Shared definitions for the AVR run/halt/step sequencer: FSM state codes and
// default timing parameters.
package runctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_RESET = 3'd0;
  localparam state_t S_HALT  = 3'd1;
  localparam state_t S_RUN   = 3'd2;
  localparam state_t S_STEP  = 3'd3;
  localparam state_t S_PROG  = 3'd4;

  localparam int DEB_CYC_DEF        = 50000;
  localparam int PROG_IDLE_CYC_DEF  = 1000000;
  localparam int RESET_HOLD_CYC_DEF = 16;
  localparam int DIV_W_DEF          = 8;

  // States in which the core is allowed out of reset.
  function automatic logic core_live(input state_t s);
    return (s == S_HALT) || (s == S_RUN) || (s == S_STEP);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-clock
// pulse on each accepted press (debounced rising edge).
module btn_debounce
  import runctrl_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the accepted level restarts the stability count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYC - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer producing the AVR core clock-enable and reset.
// Optional PC breakpoint compiled in when RUNCTRL_BP_EN is defined.
module cpu_run_ctrl
  import runctrl_pkg::*;
#(
  parameter int DEB_CYC        = DEB_CYC_DEF,
  parameter int PROG_IDLE_CYC  = PROG_IDLE_CYC_DEF,
  parameter int RESET_HOLD_CYC = RESET_HOLD_CYC_DEF,
  parameter int DIV_W          = DIV_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_we,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic [2:0]  div_sel,
  input  logic [15:0] pc,
  input  logic [15:0] bp_addr,
  input  logic        bp_en,
  output logic        core_ce,
  output logic        core_rst_n,
  output logic [2:0]  state,
  output logic        bp_hit
);

  localparam int HW = $clog2(RESET_HOLD_CYC + 1);
  localparam int IW = $clog2(PROG_IDLE_CYC + 1);

  logic [1:0] btn_raw;
  logic [1:0] press;
  logic       run_press, step_press;

  assign btn_raw    = {btn_step, btn_run};
  assign run_press  = press[0];
  assign step_press = press[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_raw[gi]),
      .press_o (press[gi])
    );
  end

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       rate_q, rate_d;
  logic             ce_q, ce_d;
  logic             rst_n_q, rst_n_d;
  logic             bp_hit_q, bp_hit_d;
  logic             skip_q, skip_d;
  logic             tick;
  logic             bp_match;
  logic [DIV_W-1:0] div_term;

  assign div_term = (DIV_W'(1) << rate_q) - DIV_W'(1);
  assign tick     = (div_q == div_term);

`ifdef RUNCTRL_BP_EN
  // skip_q lets the first tick after a halt execute the breakpointed word.
  assign bp_match = bp_en && (pc == bp_addr) && !skip_q;
`else
  logic unused_bp;
  assign bp_match  = 1'b0;
  assign unused_bp = ^{pc, bp_addr, bp_en, skip_q};
`endif

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    idle_d   = idle_q;
    div_d    = div_q;
    rate_d   = rate_q;
    ce_d     = 1'b0;
    bp_hit_d = bp_hit_q;
    skip_d   = skip_q;
    if (run_press || step_press) bp_hit_d = 1'b0;
    if (prog_we) begin
      state_d = S_PROG;
      idle_d  = '0;
    end else begin
      case (state_q)
        S_RESET: begin
          if (hold_q == HW'(RESET_HOLD_CYC - 1)) begin
            state_d = S_HALT;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        S_PROG: begin
          if (idle_q == IW'(PROG_IDLE_CYC - 1)) begin
            state_d = S_RESET;
            idle_d  = '0;
            hold_d  = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        S_HALT: begin
          if (run_press) begin
            state_d = S_RUN;
            div_d   = '0;
            rate_d  = div_sel;
            skip_d  = 1'b1;
          end else if (step_press) begin
            state_d = S_STEP;
            div_d   = '0;
            rate_d  = div_sel;
          end
        end
        S_RUN: begin
          if (run_press) begin
            state_d = S_HALT;
          end else if (tick) begin
            div_d  = '0;
            rate_d = div_sel;
            skip_d = 1'b0;
            if (bp_match) begin
              state_d  = S_HALT;
              bp_hit_d = 1'b1;
            end else begin
              ce_d = 1'b1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        S_STEP: begin
          if (tick) begin
            ce_d    = 1'b1;
            state_d = S_HALT;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        default: state_d = S_RESET;
      endcase
    end
    // ce is only ever raised alongside a live next state, so it cannot overlap reset.
    rst_n_d = core_live(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RESET;
      hold_q   <= '0;
      idle_q   <= '0;
      div_q    <= '0;
      rate_q   <= '0;
      ce_q     <= 1'b0;
      rst_n_q  <= 1'b0;
      bp_hit_q <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      idle_q   <= idle_d;
      div_q    <= div_d;
      rate_q   <= rate_d;
      ce_q     <= ce_d;
      rst_n_q  <= rst_n_d;
      bp_hit_q <= bp_hit_d;
      skip_q   <= skip_d;
    end
  end

  assign core_ce    = ce_q;
  assign core_rst_n = rst_n_q;
  assign state      = state_q;
  assign bp_hit     = bp_hit_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: expected ce cycles and sampled output
// values are queued by the stimulus and checked by a single monitor process.
module tb_cpu_run_ctrl;
  import runctrl_pkg::*;

  localparam int DEB  = 4;
  localparam int IDLE = 64;
  localparam int HOLD = 4;
  localparam int LAT  = 7;  // raw press -> FSM entry edge: 2 sync + DEB stable + 1

  localparam int SIG_STATE = 0;
  localparam int SIG_RSTN  = 1;
  localparam int SIG_CE    = 2;
  localparam int SIG_BP    = 3;
  localparam int SIG_PEND  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we, btn_run, btn_step, bp_en;
  logic [2:0]  div_sel;
  logic [15:0] pc, bp_addr;
  logic        core_ce, core_rst_n, bp_hit;
  logic [2:0]  state;
  logic        async_probe = 1'b0;

  cpu_run_ctrl #(
    .DEB_CYC(DEB), .PROG_IDLE_CYC(IDLE), .RESET_HOLD_CYC(HOLD), .DIV_W(8)
  ) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .btn_run(btn_run), .btn_step(btn_step),
    .div_sel(div_sel), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .core_ce(core_ce), .core_rst_n(core_rst_n), .state(state), .bp_hit(bp_hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: pc advances once per executed ce.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (core_ce) pc <= pc + 16'd1;
  end

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } chk_t;

  chk_t chk_q[$];
  int   ce_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int sig_val(input int s);
    case (s)
      SIG_STATE: return int'(state);
      SIG_RSTN:  return int'(core_rst_n);
      SIG_CE:    return int'(core_ce);
      SIG_BP:    return int'(bp_hit);
      SIG_PEND:  return ce_q.size();
      default:   return -1;
    endcase
  endfunction

  // Monitor: pops an expected cycle on every ce pulse, then checks queued samples.
  always @(negedge clk or posedge async_probe) begin
    int want_cyc;
    int got;
    int exp_c;
    want_cyc = async_probe ? -1 : cyc;
    if (!async_probe && core_ce) begin
      $display("ce cyc=%0d pc=%04h state=%0d", cyc, pc, state);
      checks++;
      if (ce_q.size() == 0) begin
        errors++;
        $display("FAIL ce_unexpected cyc=%0d got=ce want=no_ce", cyc);
      end else begin
        exp_c = ce_q.pop_front();
        if (exp_c != cyc) begin
          errors++;
          $display("FAIL ce_cycle got=%0d want=%0d", cyc, exp_c);
        end
      end
      checks++;
      if (!core_rst_n) begin
        errors++;
        $display("FAIL ce_in_reset cyc=%0d got=core_rst_n=0 want=1", cyc);
      end
    end
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].cyc == want_cyc) begin
        got = sig_val(chk_q[i].sig);
        checks++;
        if (got != chk_q[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%0d want=%0d", chk_q[i].name, cyc, got, chk_q[i].val);
        end
        chk_q.delete(i);
      end
    end
  end

  task automatic expect_at(input int c, input int s, input int v, input string name);
    chk_t r;
    r.cyc = c; r.sig = s; r.val = v; r.name = name;
    chk_q.push_back(r);
  endtask

  task automatic push_ce(input int entry, input int period, input int last_edge);
    for (int e = entry + period; e <= last_edge; e += period) ce_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; c0 is that cycle.
  task automatic btn_down(input logic r, input logic s, output int c0);
    c0 = cyc;
    btn_run = r;
    btn_step = s;
  endtask

  task automatic btn_up(input int c0);
    wait_until(c0 + 8);
    btn_run = 1'b0;
    btn_step = 1'b0;
    wait_until(c0 + 16);
  endtask

  initial begin
    int c0, c1, c2, cr, cp, last, g, entry;
    rst = 1'b1; prog_we = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
    div_sel = 3'd0; bp_addr = 16'h0010; bp_en = 1'b0;

    // Reset state and release sequence.
    expect_at(2, SIG_STATE, int'(S_RESET), "rst_state");
    expect_at(2, SIG_RSTN, 0, "rst_core_rst_n");
    expect_at(2, SIG_CE, 0, "rst_core_ce");
    expect_at(2, SIG_BP, 0, "rst_bp_hit");
    cr = 3;
    expect_at(cr + 1, SIG_STATE, int'(S_RESET), "hold_state");
    expect_at(cr + 3, SIG_RSTN, 0, "hold_core_rst_n");
    expect_at(cr + 4, SIG_STATE, int'(S_HALT), "hold_done_state");
    expect_at(cr + 4, SIG_RSTN, 1, "hold_done_core_rst_n");
    wait_until(cr);
    rst = 1'b0;
    wait_until(cr + 10);

    // Breakpoint run at div_sel=1 (tick every 2 clk).
    div_sel = 3'd1; bp_en = 1'b1;
    btn_down(1'b1, 1'b0, c0);
    entry = c0 + LAT;
`ifdef RUNCTRL_BP_EN
    push_ce(entry, 2, entry + 32);
    expect_at(entry + 35, SIG_STATE, int'(S_HALT), "bp_halt_state");
    expect_at(entry + 35, SIG_BP, 1, "bp_hit_set");
    btn_up(c0);
    wait_until(entry + 36);
    btn_down(1'b1, 1'b0, c1);
    push_ce(c1 + LAT, 2, c1 + 26);
    expect_at(c1 + 6, SIG_BP, 1, "bp_hit_sticky");
    expect_at(c1 + LAT, SIG_BP, 0, "bp_hit_cleared");
    btn_up(c1);
    wait_until(c1 + 20);
`else
    push_ce(entry, 2, c0 + 66);
    expect_at(entry + 35, SIG_STATE, int'(S_RUN), "nobp_state");
    expect_at(entry + 35, SIG_BP, 0, "nobp_bp_hit");
    btn_up(c0);
    wait_until(c0 + 60);
`endif
    btn_down(1'b1, 1'b0, c2);
    expect_at(c2 + LAT, SIG_STATE, int'(S_HALT), "bp_stop_state");
    btn_up(c2);
    wait_until(c2 + 20);
    bp_en = 1'b0;

    // Run/halt at div_sel=2.
    div_sel = 3'd2;
    btn_down(1'b1, 1'b0, c0);
    entry = c0 + LAT;
    expect_at(c0 + 6, SIG_STATE, int'(S_HALT), "run_pre_state");
    expect_at(entry, SIG_STATE, int'(S_RUN), "run_entry_state");
    push_ce(entry, 4, c0 + 46);
    btn_up(c0);
    wait_until(c0 + 40);
    btn_down(1'b1, 1'b0, c2);
    expect_at(c2 + 6, SIG_STATE, int'(S_RUN), "stop_pre_state");
    expect_at(c2 + LAT, SIG_STATE, int'(S_HALT), "stop_state");
    btn_up(c2);
    wait_until(c2 + 20);

    // Single step at div_sel=0.
    div_sel = 3'd0;
    btn_down(1'b0, 1'b1, c0);
    expect_at(c0 + LAT, SIG_STATE, int'(S_STEP), "step_state");
    expect_at(c0 + 8, SIG_STATE, int'(S_HALT), "step_done_state");
    ce_q.push_back(c0 + 8);
    btn_up(c0);
    wait_until(c0 + 25);

    // Two-clock glitch on btn_step must be rejected.
    g = cyc;
    btn_step = 1'b1;
    wait_until(g + 2);
    btn_step = 1'b0;
    expect_at(g + 15, SIG_STATE, int'(S_HALT), "glitch_state");
    wait_until(g + 16);

    // Programming while running.
    div_sel = 3'd2;
    btn_down(1'b1, 1'b0, c0);
    entry = c0 + LAT;
    cp = c0 + 30;
    last = cp + 40;
    push_ce(entry, 4, cp);
    expect_at(cp, SIG_STATE, int'(S_RUN), "prog_pre_state");
    expect_at(cp + 1, SIG_STATE, int'(S_PROG), "prog_state");
    expect_at(cp + 1, SIG_RSTN, 0, "prog_core_rst_n");
    expect_at(cp + 1, SIG_CE, 0, "prog_core_ce");
    expect_at(last + 64, SIG_STATE, int'(S_PROG), "prog_idle_state");
    expect_at(last + 65, SIG_STATE, int'(S_RESET), "prog_exit_state");
    expect_at(last + 68, SIG_RSTN, 0, "prog_hold_core_rst_n");
    expect_at(last + 69, SIG_STATE, int'(S_HALT), "prog_halt_state");
    expect_at(last + 69, SIG_RSTN, 1, "prog_halt_core_rst_n");
    btn_up(c0);
    for (int i = 0; i < 5; i++) begin
      wait_until(cp + 10 * i);
      prog_we = 1'b1;
      @(negedge clk);
      prog_we = 1'b0;
    end
    wait_until(last + 75);

    // Simultaneous run+step acts as run, then async reset mid-run.
    div_sel = 3'd2;
    btn_down(1'b1, 1'b1, c0);
    entry = c0 + LAT;
    expect_at(entry, SIG_STATE, int'(S_RUN), "both_state");
    ce_q.push_back(entry + 4);
    wait_until(c0 + 8);
    btn_run = 1'b0;
    btn_step = 1'b0;
    wait_until(entry + 4);
    #2;
    rst = 1'b1;
    expect_at(-1, SIG_STATE, int'(S_RESET), "async_state");
    expect_at(-1, SIG_RSTN, 0, "async_core_rst_n");
    expect_at(-1, SIG_CE, 0, "async_core_ce");
    expect_at(-1, SIG_BP, 0, "async_bp_hit");
    #1 async_probe = 1'b1;
    #1 async_probe = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    c1 = cyc;
    expect_at(c1 + 5, SIG_STATE, int'(S_HALT), "rerelease_state");
    expect_at(c1 + 12, SIG_PEND, 0, "ce_pending");
    wait_until(c1 + 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
